lm_rf_write_sched: RTL and testbench
====================================

# lm_rf_write_sched

Sequencer and write-port arbiter for the register file's single write port. It merges two writers: single-cycle results from the write-back stage, and multi-register bursts of the Load-Multiple (LM) instruction. For an LM, it walks the register mask, fetches each word over a memory read handshake, and inserts the write into the port whenever the write-back stage leaves it idle. It sits between the write-back stage, the data-memory read port and the register file.

## Interface
Parameters:
- DATA_W, 16, register and memory word width.
- NREG, 8, number of architectural registers. Mask width is NREG; register address width is clog2(NREG)=3.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  reset, synchronous, active-low.
- wb_valid  in  1  write-back stage requests a register write this cycle.
- wb_addr  in  3  write-back destination register.
- wb_data  in  DATA_W  write-back data.
- lm_start  in  1  one-cycle LM launch pulse.
- lm_mask  in  NREG  LM register mask; bit i set means load Ri.
- lm_base  in  DATA_W  LM starting memory address.
- lm_busy  out  1  LM sequence in progress.
- lm_done  out  1  one-cycle pulse when the LM sequence completes.
- mem_rd_req  out  1  memory read request.
- mem_rd_addr  out  DATA_W  memory read address.
- mem_rd_ack  in  1  read data valid; completes the request.
- mem_rd_data  in  DATA_W  read data.
- rf_we  out  1  register file write enable.
- rf_waddr  out  3  register file write address.
- rf_wdata  out  DATA_W  register file write data.

## Operation
- States:
  - IDLE: waiting for lm_start.
  - SCAN: select the next register.
  - RD: memory read outstanding.
  - WR: write pending in the buffer.
  - DONE: sequence complete.
- IDLE:
  - lm_start=1 latches lm_mask into rem_mask, lm_base into addr_q, goes to SCAN.
  - lm_start is ignored in every state other than IDLE.
- SCAN:
  - rem_mask==0 goes to DONE. This covers an empty mask at start.
  - Otherwise lowest set bit index i goes to cur_reg, then go to RD.
- RD:
  - mem_rd_req=1, mem_rd_addr=addr_q, both held stable until mem_rd_ack.
  - On ack: mem_rd_data goes to buf_data, clear bit cur_reg in rem_mask, addr_q <= addr_q+1 (mod 2^DATA_W, wraps 0xFFFF->0x0000), go to WR.
- WR:
  - Write-back has absolute priority. If wb_valid=1, hold.
  - Else drive the buffered write: rf_we=1, rf_waddr=cur_reg, rf_wdata=buf_data. Go to SCAN.
- DONE: lm_done=1 for exactly one cycle, then IDLE.
- lm_busy=1 in SCAN, RD, WR, DONE.
- Port mux (combinational):
  - wb_valid=1: port carries wb_addr/wb_data in the same cycle, in every state.
  - Else, in WR: port carries the LM buffer.
  - Else: rf_we=0.
- Same register from both sources: write-back write lands first, LM write lands later and is final.

## Timing
- Reset (resetn=0 at a rising edge):
  - State goes to IDLE.
  - rem_mask, addr_q, buf_data, cur_reg clear to 0.
  - Outputs while resetn=0: rf_we=0, rf_waddr=0, rf_wdata=0, mem_rd_req=0, mem_rd_addr=0, lm_busy=0, lm_done=0. wb_valid is masked during reset.
- Reset mid-sequence aborts: outstanding request dropped, buffer discarded, no lm_done.
- Write-back path latency: 0 cycles (combinational pass-through).
- LM cost per register: 1 (SCAN) + ack wait (≥1) + 1 + write-back stall cycles (WR).
- Minimum LM of k registers: lm_start at cycle 0 gives lm_done at cycle 3k+2.
- Empty mask: lm_done at cycle 2.
- Only one read is outstanding at a time. No new read issues while the buffer is full.
- mem_rd_ack outside RD is ignored.

## Structure
- Shared package rf_pkg holds:
  - DATA_W, NREG, RADDR_W.
  - State enum: IDLE, SCAN, RD, WR, DONE.
- One sub-module, lsb_prio_enc: NREG-bit mask in, lowest-set index plus any-set flag out. Purely combinational.
- The top level contains the FSM, the datapath registers and the port mux.

## Test plan
- Plain write-back: wb_valid=1, addr=3, data=0xBEEF with no LM active -> rf_we=1, rf_waddr=3, rf_wdata=0xBEEF in the same cycle.
- LM, mask=0x05, base=0x0100, ack returns 0x1111 then 0x2222 after 1 cycle each -> reads at 0x0100 and 0x0101; R0=0x1111, R2=0x2222; lm_done at cycle 8.
- Contention: during WR for R2, hold wb_valid=1 (addr=2, data=0xAAAA) for 3 cycles -> write-back writes three times; LM write of R2 follows on cycle 4; R2 ends holding the LM data.
- Empty mask, and base=0xFFFF with mask=0x03 -> empty mask gives no mem_rd_req and lm_done at cycle 2; second case gives reads at 0xFFFF then 0x0000.
- Second lm_start while busy is ignored. resetn=0 during RD -> mem_rd_req=0 the next cycle, lm_busy=0, no lm_done, no rf_we from the LM.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared parameters and FSM state encoding for the register-file write scheduler.
package rf_pkg;

   localparam int DATA_W  = 16;
   localparam int NREG    = 8;
   localparam int RADDR_W = $clog2(NREG);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      RD,
      WR,
      DONE
   } lm_state_e;

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index of the least significant set bit plus an any-set flag.
module lsb_prio_enc #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] mask,
   output logic [W-1:0] idx,
   output logic         any
);

   // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      idx = '0;
      any = 1'b0;
      // Scan from the top down so the last hit, the lowest index, wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx = W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lm_rf_write_sched.sv
// Register-file write-port scheduler: merges write-back results with Load-Multiple bursts,
// giving write-back absolute priority and slotting LM writes into idle port cycles.
module lm_rf_write_sched
   import rf_pkg::*;
#(
   parameter  int DATA_W  = rf_pkg::DATA_W,
   parameter  int NREG    = rf_pkg::NREG,
   localparam int RADDR_W = $clog2(NREG)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               wb_valid,
   input  logic [RADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   input  logic               lm_start,
   input  logic [NREG-1:0]    lm_mask,
   input  logic [DATA_W-1:0]  lm_base,
   output logic               lm_busy,
   output logic               lm_done,
   output logic               mem_rd_req,
   output logic [DATA_W-1:0]  mem_rd_addr,
   input  logic               mem_rd_ack,
   input  logic [DATA_W-1:0]  mem_rd_data,
   output logic               rf_we,
   output logic [RADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]  rf_wdata
);

   lm_state_e          state_q, state_d;
   logic [NREG-1:0]    rem_mask;
   logic [DATA_W-1:0]  addr_q;
   logic [DATA_W-1:0]  buf_data;
   logic [RADDR_W-1:0] cur_reg;
   logic [RADDR_W-1:0] enc_idx;
   logic               enc_any;

   lsb_prio_enc #(.N(NREG)) u_enc (
      .mask (rem_mask),
      .idx  (enc_idx),
      .any  (enc_any)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (lm_start) state_d = SCAN;
         SCAN:    state_d = enc_any ? RD : DONE;
         RD:      if (mem_rd_ack) state_d = WR;
         WR:      if (!wb_valid) state_d = SCAN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the datapath registers are plain flops, so the synchronous reset clears them
   // alongside the state; an aborted sequence leaves nothing stale behind.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= IDLE;
         rem_mask <= '0;
         addr_q   <= '0;
         buf_data <= '0;
         cur_reg  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (lm_start) begin
                  rem_mask <= lm_mask;
                  addr_q   <= lm_base;
               end
            end
            SCAN: begin
               if (enc_any) cur_reg <= enc_idx;
            end
            RD: begin
               if (mem_rd_ack) begin
                  buf_data          <= mem_rd_data;
                  rem_mask[cur_reg] <= 1'b0;
                  addr_q            <= addr_q + DATA_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are gated with resetn so they read as zero for the whole reset cycle,
   // including the write-back pass-through.
   assign lm_busy     = resetn && (state_q != IDLE);
   assign lm_done     = resetn && (state_q == DONE);
   assign mem_rd_req  = resetn && (state_q == RD);
   assign mem_rd_addr = resetn ? addr_q : '0;

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (resetn) begin
         if (wb_valid) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
         end else if (state_q == WR) begin
            rf_we    = 1'b1;
            rf_waddr = cur_reg;
            rf_wdata = buf_data;
         end
      end
   end

endmodule

// File: tb/tb_lm_rf_write_sched.sv
// Self-checking bench for lm_rf_write_sched: directed scenarios plus randomized LM bursts
// mixed with write-back traffic, checked against a list-level model of reads and writes.
module tb_lm_rf_write_sched;
   import rf_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        wb_valid = 1'b0;
   logic [2:0]  wb_addr = '0;
   logic [15:0] wb_data = '0;
   logic        lm_start = 1'b0;
   logic [7:0]  lm_mask = '0;
   logic [15:0] lm_base = '0;
   logic        lm_busy, lm_done, mem_rd_req;
   logic [15:0] mem_rd_addr;
   logic        mem_rd_ack = 1'b0;
   logic [15:0] mem_rd_data = '0;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;

   lm_rf_write_sched dut (
      .clk         (clk),
      .resetn      (resetn),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .lm_start    (lm_start),
      .lm_mask     (lm_mask),
      .lm_base     (lm_base),
      .lm_busy     (lm_busy),
      .lm_done     (lm_done),
      .mem_rd_req  (mem_rd_req),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_ack  (mem_rd_ack),
      .mem_rd_data (mem_rd_data),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  a;
      logic [15:0] d;
   } wr_t;

   wr_t         wr_log[$];
   wr_t         exp_wr[$];
   logic [15:0] rd_log[$];
   logic [15:0] exp_rd[$];
   int          done_log[$];
   logic [15:0] mem_img [logic [15:0]];
   logic [15:0] shadow [8];
   logic [15:0] exp_rf [8];
   wr_t         w_e;
   int          cyc = 0;
   int          t0 = 0;
   int          ack_delay = 0;
   int          wait_cnt = 0;
   bit          spurious = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      if (mem_img.exists(a)) return mem_img[a];
      return (a * 16'd7) ^ 16'hC3A5;
   endfunction

   always @(posedge clk) cyc = cyc + 1;

   // Monitor and memory responder, both on the falling edge.
   always @(negedge clk) begin
      if (rf_we) begin
         w_e.a = rf_waddr;
         w_e.d = rf_wdata;
         wr_log.push_back(w_e);
         shadow[rf_waddr] = rf_wdata;
      end
      if (lm_done) done_log.push_back(cyc);
      if (mem_rd_req) begin
         if (wait_cnt >= ack_delay) begin
            mem_rd_ack  = 1'b1;
            mem_rd_data = mem_rd(mem_rd_addr);
            rd_log.push_back(mem_rd_addr);
            wait_cnt = 0;
         end else begin
            mem_rd_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_rd_ack  = spurious && ($urandom_range(0, 1) == 1);
         mem_rd_data = 16'($urandom);
         wait_cnt    = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_lm(input logic [7:0] m, input logic [15:0] b);
      tick();
      lm_start = 1'b1;
      lm_mask  = m;
      lm_base  = b;
      t0       = cyc;
      wr_log.delete();
      rd_log.delete();
      done_log.delete();
      tick();
      lm_start = 1'b0;
   endtask

   // Expected reads and LM writes: j-th set bit (lowest first) loads from base+j.
   task automatic model_lm(input logic [7:0] m, input logic [15:0] b);
      int j = 0;
      wr_t e;
      exp_rd.delete();
      exp_wr.delete();
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            exp_rd.push_back(16'(b + j));
            e.a = 3'(i);
            e.d = mem_rd(16'(b + j));
            exp_wr.push_back(e);
            j++;
         end
      end
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      dcyc = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done_log.size() != 0) begin
            dcyc = done_log[0] - t0;
            break;
         end
      end
   endtask

   function automatic bit rd_match();
      if (rd_log.size() != exp_rd.size()) return 1'b0;
      foreach (rd_log[i]) if (rd_log[i] !== exp_rd[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit lm_wr_match(input logic [7:0] m);
      int j = 0;
      foreach (wr_log[i]) begin
         if (m[wr_log[i].a]) begin
            if (j >= exp_wr.size() || wr_log[i] !== exp_wr[j]) return 1'b0;
            j++;
         end
      end
      return j == exp_wr.size();
   endfunction

   task automatic test_reset();
      resetn   = 1'b0;
      wb_valid = 1'b1;
      wb_addr  = 3'd5;
      wb_data  = 16'h1234;
      lm_start = 1'b1;
      lm_mask  = 8'hFF;
      tick();
      tick();
      @(negedge clk);
      n_checks++;
      if ({rf_we, rf_waddr, rf_wdata, mem_rd_req, mem_rd_addr, lm_busy, lm_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h req=%b ra=%h busy=%b done=%b, want all 0",
                  rf_we, rf_waddr, rf_wdata, mem_rd_req, mem_rd_addr, lm_busy, lm_done);
      end
      tick();
      resetn   = 1'b1;
      wb_valid = 1'b0;
      lm_start = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if (lm_busy !== 1'b0 || mem_rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b req=%b, want 0 0", lm_busy, mem_rd_req);
      end
   endtask

   task automatic test_wb();
      tick();
      wb_valid = 1'b1;
      wb_addr  = 3'd3;
      wb_data  = 16'hBEEF;
      @(negedge clk);
      n_checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL wb_pass: got we=%b wa=%0d wd=%h, want 1 3 beef", rf_we, rf_waddr, rf_wdata);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         wb_addr = 3'($urandom);
         wb_data = 16'($urandom);
         @(negedge clk);
         n_checks++;
         if (rf_we !== 1'b1 || rf_waddr !== wb_addr || rf_wdata !== wb_data) begin
            n_fail++;
            $display("FAIL wb_rand: got we=%b wa=%0d wd=%h, want 1 %0d %h",
                     rf_we, rf_waddr, rf_wdata, wb_addr, wb_data);
         end
      end
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL wb_idle: got we=%b, want 0", rf_we);
      end
   endtask

   task automatic test_lm_basic();
      int dcyc;
      ack_delay = 0;
      mem_img[16'h0100] = 16'h1111;
      mem_img[16'h0101] = 16'h2222;
      start_lm(8'h05, 16'h0100);
      model_lm(8'h05, 16'h0100);
      @(negedge clk);
      n_checks++;
      if (lm_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL lm_basic_busy: got %b, want 1", lm_busy);
      end
      wait_done(40, dcyc);
      n_checks++;
      if (dcyc != 8) begin
         n_fail++;
         $display("FAIL lm_basic_done: got cycle %0d, want 8", dcyc);
      end
      n_checks++;
      if (!rd_match() || rd_log.size() != 2 || rd_log[0] !== 16'h0100 || rd_log[1] !== 16'h0101) begin
         n_fail++;
         $display("FAIL lm_basic_reads: got %0d reads, want 0100,0101", rd_log.size());
      end
      n_checks++;
      if (!lm_wr_match(8'h05) || wr_log.size() != 2 || shadow[0] !== 16'h1111 || shadow[2] !== 16'h2222) begin
         n_fail++;
         $display("FAIL lm_basic_writes: got %0d writes R0=%h R2=%h, want 2 writes 1111 2222",
                  wr_log.size(), shadow[0], shadow[2]);
      end
      n_checks++;
      if (lm_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL lm_basic_idle: got busy=%b, want 0", lm_busy);
      end
   endtask

   task automatic test_contention();
      int dcyc;
      ack_delay = 0;
      start_lm(8'h04, 16'h0200);
      model_lm(8'h04, 16'h0200);
      tick();
      tick();
      wb_valid = 1'b1;
      wb_addr  = 3'd2;
      wb_data  = 16'hAAAA;
      tick();
      tick();
      tick();
      wb_valid = 1'b0;
      wait_done(40, dcyc);
      n_checks++;
      if (dcyc != 8) begin
         n_fail++;
         $display("FAIL contention_done: got cycle %0d, want 8", dcyc);
      end
      n_checks++;
      if (wr_log.size() != 4 || wr_log[0] !== {3'd2, 16'hAAAA} || wr_log[1] !== {3'd2, 16'hAAAA} ||
          wr_log[2] !== {3'd2, 16'hAAAA} || wr_log[3] !== exp_wr[0]) begin
         n_fail++;
         $display("FAIL contention_order: got %0d writes, want 3x aaaa then LM data %h",
                  wr_log.size(), exp_wr[0].d);
      end
      n_checks++;
      if (shadow[2] !== mem_rd(16'h0200)) begin
         n_fail++;
         $display("FAIL contention_final: got R2=%h, want %h", shadow[2], mem_rd(16'h0200));
      end
   endtask

   task automatic test_empty_and_wrap();
      int dcyc;
      ack_delay = 0;
      start_lm(8'h00, 16'h1234);
      wait_done(20, dcyc);
      n_checks++;
      if (dcyc != 2 || rd_log.size() != 0 || wr_log.size() != 0) begin
         n_fail++;
         $display("FAIL empty_mask: got done=%0d reads=%0d writes=%0d, want 2 0 0",
                  dcyc, rd_log.size(), wr_log.size());
      end
      start_lm(8'h03, 16'hFFFF);
      model_lm(8'h03, 16'hFFFF);
      wait_done(40, dcyc);
      n_checks++;
      if (dcyc != 8) begin
         n_fail++;
         $display("FAIL wrap_done: got cycle %0d, want 8", dcyc);
      end
      n_checks++;
      if (!rd_match() || rd_log[0] !== 16'hFFFF || rd_log[1] !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_reads: got %0d reads, want ffff,0000", rd_log.size());
      end
      n_checks++;
      if (!lm_wr_match(8'h03) || wr_log.size() != 2) begin
         n_fail++;
         $display("FAIL wrap_writes: got %0d writes, want R0,R1 from ffff,0000", wr_log.size());
      end
   endtask

   task automatic test_ignore_start();
      int dcyc;
      ack_delay = 0;
      start_lm(8'h01, 16'h0300);
      model_lm(8'h01, 16'h0300);
      tick();
      lm_start = 1'b1;
      lm_mask  = 8'hFF;
      lm_base  = 16'h0000;
      tick();
      lm_start = 1'b0;
      wait_done(40, dcyc);
      repeat (5) tick();
      n_checks++;
      if (dcyc != 5 || done_log.size() != 1) begin
         n_fail++;
         $display("FAIL ignore_done: got cycle %0d count %0d, want 5 1", dcyc, done_log.size());
      end
      n_checks++;
      if (!rd_match() || !lm_wr_match(8'hFF) || wr_log.size() != 1 || lm_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_effects: got reads=%0d writes=%0d busy=%b, want 1 1 0",
                  rd_log.size(), wr_log.size(), lm_busy);
      end
   endtask

   task automatic test_reset_mid();
      int dcyc;
      ack_delay = 6;
      start_lm(8'h03, 16'h0400);
      tick();
      @(negedge clk);
      n_checks++;
      if (mem_rd_req !== 1'b1 || mem_rd_addr !== 16'h0400) begin
         n_fail++;
         $display("FAIL mid_rd: got req=%b addr=%h, want 1 0400", mem_rd_req, mem_rd_addr);
      end
      tick();
      resetn = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if (mem_rd_req !== 1'b0 || lm_busy !== 1'b0 || lm_done !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got req=%b busy=%b done=%b, want 0 0 0", mem_rd_req, lm_busy, lm_done);
      end
      tick();
      resetn    = 1'b1;
      ack_delay = 0;
      repeat (6) tick();
      n_checks++;
      if (done_log.size() != 0 || wr_log.size() != 0 || rd_log.size() != 0 || lm_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_abort: got done=%0d writes=%0d reads=%0d busy=%b, want 0 0 0 0",
                  done_log.size(), wr_log.size(), rd_log.size(), lm_busy);
      end
      start_lm(8'h02, 16'h0500);
      model_lm(8'h02, 16'h0500);
      wait_done(40, dcyc);
      n_checks++;
      if (dcyc != 5 || !rd_match() || !lm_wr_match(8'h02)) begin
         n_fail++;
         $display("FAIL mid_restart: got done=%0d reads=%0d writes=%0d, want 5 1 1",
                  dcyc, rd_log.size(), wr_log.size());
      end
   endtask

   task automatic test_random();
      logic [7:0]  m;
      logic [15:0] b;
      logic [2:0]  r;
      int          wb_cnt;
      int          dcyc;
      for (int i = 0; i < 8; i++) begin
         tick();
         wb_valid = 1'b1;
         wb_addr  = 3'(i);
         wb_data  = 16'($urandom);
         exp_rf[i] = wb_data;
      end
      tick();
      wb_valid = 1'b0;
      spurious = 1'b1;
      for (int n = 0; n < 10; n++) begin
         m = 8'($urandom);
         b = 16'($urandom);
         ack_delay = $urandom_range(0, 3);
         start_lm(m, b);
         model_lm(m, b);
         wb_cnt = 0;
         dcyc   = -1;
         for (int k = 0; k < 200; k++) begin
            tick();
            if (done_log.size() != 0) begin
               dcyc = done_log[0] - t0;
               break;
            end
            if (m != 8'hFF && $urandom_range(0, 2) == 0) begin
               r = 3'($urandom);
               while (m[r]) r = 3'($urandom);
               wb_valid = 1'b1;
               wb_addr  = r;
               wb_data  = 16'($urandom);
               exp_rf[r] = wb_data;
               wb_cnt++;
            end else begin
               wb_valid = 1'b0;
            end
         end
         wb_valid = 1'b0;
         foreach (exp_wr[j]) exp_rf[exp_wr[j].a] = exp_wr[j].d;
         n_checks++;
         if (dcyc < 2 || !rd_match()) begin
            n_fail++;
            $display("FAIL rand_reads[%0d]: mask=%h base=%h done=%0d reads=%0d, want %0d reads",
                     n, m, b, dcyc, rd_log.size(), exp_rd.size());
         end
         n_checks++;
         if (!lm_wr_match(m) || wr_log.size() != wb_cnt + exp_wr.size()) begin
            n_fail++;
            $display("FAIL rand_writes[%0d]: mask=%h got %0d writes, want %0d",
                     n, m, wr_log.size(), wb_cnt + exp_wr.size());
         end
         for (int q = 0; q < 8; q++) begin
            n_checks++;
            if (shadow[q] !== exp_rf[q]) begin
               n_fail++;
               $display("FAIL rand_rf[%0d] R%0d: got %h, want %h", n, q, shadow[q], exp_rf[q]);
            end
         end
      end
      spurious = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wb();
      test_lm_basic();
      test_contention();
      test_empty_and_wrap();
      test_ignore_start();
      test_reset_mid();
      test_random();
      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
